// File: rtl/zeroriscy_defines.sv
// Shared definitions for the fetch/LSU memory arbiter: owner encoding
// and the fixed fetch byte-enable pattern.
package zeroriscy_defines;

   typedef enum logic {
      OWNER_INSTR = 1'b0,
      OWNER_DATA  = 1'b1
   } owner_e;

   localparam logic [3:0] FETCH_BE = 4'b1111;

endpackage

// File: rtl/zeroriscy_arb_owner_fifo.sv
// In-order tracker of granted bus transactions; each 1-bit entry names the
// requester that owns the next response.
module zeroriscy_arb_owner_fifo #(
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push_i,
   input  logic                         din_i,
   input  logic                         pop_i,
   output logic                         head_o,
   output logic                         full_o,
   output logic                         empty_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);

   logic [DEPTH-1:0] mem_q;
   logic [PW-1:0]    wptr_q, wptr_d;
   logic [PW-1:0]    rptr_q, rptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      // Depth need not be a power of two, so wrap explicitly.
      if (p == PW'(DEPTH-1)) return '0;
      return p + 1'b1;
   endfunction

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = mem_q[rptr_q];

   assign do_push = push_i && (!full_o || pop_i);
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (do_push) wptr_d = ptr_inc(wptr_q);
      if (do_pop)  rptr_d = ptr_inc(rptr_q);
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (do_pop && !do_push) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q   <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) mem_q[wptr_q] <= din_i;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/zeroriscy_mem_arbiter.sv
// Shares one req/gnt/rvalid memory port between instruction fetch and the
// LSU. Data is favoured; a streak counter forces fetch through eventually.
module zeroriscy_mem_arbiter
   import zeroriscy_defines::*;
#(
   parameter int MAX_OUTSTANDING = 2,
   parameter int DATA_STREAK_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,

   input  logic        instr_req_i,
   input  logic [31:0] instr_addr_i,
   output logic        instr_gnt_o,
   output logic        instr_rvalid_o,
   output logic [31:0] instr_rdata_o,

   input  logic        data_req_i,
   input  logic [31:0] data_addr_i,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_wdata_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   output logic [31:0] data_rdata_o,

   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,

   output logic        spurious_rvalid_o
);

   localparam int CW = $clog2(MAX_OUTSTANDING+1);

   logic       lock_q, lock_d;
   owner_e     lock_owner_q, lock_owner_d;
   logic [3:0] streak_q, streak_d;

   logic       lock_hold;
   owner_e     sel_owner;
   logic       sel_req;
   logic       bus_req;

   logic          fifo_push, fifo_pop, fifo_head;
   logic          fifo_full, fifo_empty;
   logic [CW-1:0] fifo_count;

   always_comb begin
      // A locked owner that drops its request forfeits the lock.
      lock_hold = lock_q && ((lock_owner_q == OWNER_INSTR) ? instr_req_i : data_req_i);
      sel_req   = instr_req_i || data_req_i;
      if (lock_hold)
         sel_owner = lock_owner_q;
      else if (instr_req_i && data_req_i)
         sel_owner = (streak_q == 4'(DATA_STREAK_MAX)) ? OWNER_INSTR : OWNER_DATA;
      else if (instr_req_i)
         sel_owner = OWNER_INSTR;
      else
         sel_owner = OWNER_DATA;
   end

   // Full is judged on registered occupancy only, so rvalid never reaches req.
   assign bus_req   = sel_req && !fifo_full && !rst;
   assign mem_req_o = bus_req;

   always_comb begin
      mem_addr_o  = '0;
      mem_we_o    = 1'b0;
      mem_be_o    = '0;
      mem_wdata_o = '0;
      if (sel_req && !rst) begin
         if (sel_owner == OWNER_INSTR) begin
            mem_addr_o = instr_addr_i;
            mem_be_o   = FETCH_BE;
         end else begin
            mem_addr_o  = data_addr_i;
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_wdata_o = data_wdata_i;
         end
      end
   end

   assign instr_gnt_o = bus_req && mem_gnt_i && (sel_owner == OWNER_INSTR);
   assign data_gnt_o  = bus_req && mem_gnt_i && (sel_owner == OWNER_DATA);

   always_comb begin
      lock_d       = lock_hold;
      lock_owner_d = lock_owner_q;
      if (bus_req && !mem_gnt_i) begin
         lock_d       = 1'b1;
         lock_owner_d = sel_owner;
      end else if (bus_req && mem_gnt_i) begin
         lock_d = 1'b0;
      end
   end

   always_comb begin
      streak_d = streak_q;
      if (data_gnt_o && instr_req_i) begin
         if (streak_q != 4'(DATA_STREAK_MAX)) streak_d = streak_q + 1'b1;
      end else if (instr_gnt_o || !instr_req_i) begin
         streak_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lock_q       <= 1'b0;
         lock_owner_q <= OWNER_INSTR;
         streak_q     <= '0;
      end else begin
         lock_q       <= lock_d;
         lock_owner_q <= lock_owner_d;
         streak_q     <= streak_d;
      end
   end

   assign fifo_push = instr_gnt_o || data_gnt_o;
   assign fifo_pop  = mem_rvalid_i && !fifo_empty && !rst;

   zeroriscy_arb_owner_fifo #(
      .DEPTH (MAX_OUTSTANDING)
   ) u_owner_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (fifo_push),
      .din_i   (data_gnt_o),
      .pop_i   (fifo_pop),
      .head_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign instr_rvalid_o    = fifo_pop && (owner_e'(fifo_head) == OWNER_INSTR);
   assign data_rvalid_o     = fifo_pop && (owner_e'(fifo_head) == OWNER_DATA);
   assign spurious_rvalid_o = mem_rvalid_i && (fifo_count == '0) && !rst;

   assign instr_rdata_o = mem_rdata_i;
   assign data_rdata_o  = mem_rdata_i;

endmodule

// File: tb/tb_zeroriscy_mem_arbiter.sv
// Directed bench for zeroriscy_mem_arbiter (MAX_OUTSTANDING=2, DATA_STREAK_MAX=4).
module tb_zeroriscy_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_req_i;
   logic [31:0] instr_addr_i;
   logic        instr_gnt_o, instr_rvalid_o;
   logic [31:0] instr_rdata_o;
   logic        data_req_i;
   logic [31:0] data_addr_i;
   logic        data_we_i;
   logic [3:0]  data_be_i;
   logic [31:0] data_wdata_i;
   logic        data_gnt_o, data_rvalid_o;
   logic [31:0] data_rdata_o;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_wdata_o;
   logic        mem_gnt_i, mem_rvalid_i;
   logic [31:0] mem_rdata_i;
   logic        spurious_rvalid_o;

   int   vectors = 0;
   int   miscompares = 0;
   logic exp_dat, prev_dat;

   always #5 clk = ~clk;

   zeroriscy_mem_arbiter #(
      .MAX_OUTSTANDING (2),
      .DATA_STREAK_MAX (4)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .instr_req_i       (instr_req_i),
      .instr_addr_i      (instr_addr_i),
      .instr_gnt_o       (instr_gnt_o),
      .instr_rvalid_o    (instr_rvalid_o),
      .instr_rdata_o     (instr_rdata_o),
      .data_req_i        (data_req_i),
      .data_addr_i       (data_addr_i),
      .data_we_i         (data_we_i),
      .data_be_i         (data_be_i),
      .data_wdata_i      (data_wdata_i),
      .data_gnt_o        (data_gnt_o),
      .data_rvalid_o     (data_rvalid_o),
      .data_rdata_o      (data_rdata_o),
      .mem_req_o         (mem_req_o),
      .mem_addr_o        (mem_addr_o),
      .mem_we_o          (mem_we_o),
      .mem_be_o          (mem_be_o),
      .mem_wdata_o       (mem_wdata_o),
      .mem_gnt_i         (mem_gnt_i),
      .mem_rvalid_i      (mem_rvalid_i),
      .mem_rdata_i       (mem_rdata_i),
      .spurious_rvalid_o (spurious_rvalid_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      instr_req_i  = 1'b0;
      instr_addr_i = '0;
      data_req_i   = 1'b0;
      data_addr_i  = '0;
      data_we_i    = 1'b0;
      data_be_i    = '0;
      data_wdata_i = '0;
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
   endtask

   initial begin
      // Reset: active inputs must not leak to outputs, rdata follows the bus.
      idle();
      rst = 1'b1;
      instr_req_i = 1'b1; instr_addr_i = 32'h40;
      data_req_i = 1'b1;  data_addr_i = 32'h50;
      mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hA5A5_A5A5;
      #1;
      chk("rst_mem_req", 32'(mem_req_o), 32'd0);
      chk("rst_gnts", 32'({instr_gnt_o, data_gnt_o}), 32'd0);
      chk("rst_rvalids", 32'({instr_rvalid_o, data_rvalid_o, spurious_rvalid_o}), 32'd0);
      chk("rst_addr", mem_addr_o, 32'd0);
      chk("rst_rdata", data_rdata_o, 32'hA5A5_A5A5);
      tick();
      idle();
      rst = 1'b0;

      // Single fetch, granted immediately, answered next cycle.
      instr_req_i = 1'b1; instr_addr_i = 32'h80; mem_gnt_i = 1'b1;
      #1;
      chk("f_mem_req", 32'(mem_req_o), 32'd1);
      chk("f_addr", mem_addr_o, 32'h80);
      chk("f_be_we", 32'({mem_be_o, mem_we_o}), 32'h1E);
      chk("f_gnts", 32'({instr_gnt_o, data_gnt_o}), 32'd2);
      tick();
      idle();
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'h13;
      #1;
      chk("f_rvalids", 32'({instr_rvalid_o, data_rvalid_o, spurious_rvalid_o}), 32'd4);
      chk("f_rdata", instr_rdata_o, 32'h13);
      tick();
      idle();

      // Continuous contention: D,D,D,D,I repeating; each response routed to prior grantee.
      instr_req_i = 1'b1; instr_addr_i = 32'h300;
      data_req_i = 1'b1;  data_addr_i = 32'h400; data_be_i = 4'hF;
      mem_gnt_i = 1'b1;
      prev_dat = 1'b0;
      for (int i = 0; i < 10; i++) begin
         mem_rvalid_i = (i > 0);
         mem_rdata_i  = 32'(i);
         #1;
         exp_dat = ((i % 5) != 4);
         chk("streak_dgnt", 32'(data_gnt_o), 32'(exp_dat));
         chk("streak_ignt", 32'(instr_gnt_o), 32'(!exp_dat));
         if (i > 0) chk("streak_rsp", 32'({instr_rvalid_o, data_rvalid_o}), prev_dat ? 32'd1 : 32'd2);
         prev_dat = exp_dat;
         tick();
      end
      idle();
      mem_rvalid_i = 1'b1;
      #1;
      chk("streak_drain", 32'({instr_rvalid_o, data_rvalid_o, spurious_rvalid_o}), 32'd4);
      tick();
      idle();

      // Data wins, bus stalls 3 cycles: stays on data address, no fetch grant.
      instr_req_i = 1'b1; instr_addr_i = 32'h200;
      data_req_i = 1'b1; data_addr_i = 32'h100; data_we_i = 1'b1;
      data_be_i = 4'b0011; data_wdata_i = 32'hDEAD;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall_addr", mem_addr_o, 32'h100);
         chk("stall_gnts", 32'({instr_gnt_o, data_gnt_o}), 32'd0);
         tick();
      end
      mem_gnt_i = 1'b1;
      #1;
      chk("stall_gnts4", 32'({instr_gnt_o, data_gnt_o}), 32'd1);
      chk("stall_fields", 32'({mem_we_o, mem_be_o}), 32'h13);
      chk("stall_wdata", mem_wdata_o, 32'hDEAD);
      tick();

      // Fetch locks the bus (count 1), a later data request must not steal it.
      data_req_i = 1'b0; mem_gnt_i = 1'b0;
      #1;
      chk("lock_i_req", 32'(mem_req_o), 32'd1);
      tick();
      data_req_i = 1'b1; data_addr_i = 32'h104; data_we_i = 1'b0; data_be_i = 4'hF;
      #1;
      chk("lock_i_addr", mem_addr_o, 32'h200);
      tick();
      mem_gnt_i = 1'b1;
      #1;
      chk("lock_i_gnts", 32'({instr_gnt_o, data_gnt_o}), 32'd2);
      tick();

      // Count 2 = full: request blocked even though a response pops this cycle.
      instr_req_i = 1'b0;
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'h11;
      #1;
      chk("full_req", 32'(mem_req_o), 32'd0);
      chk("full_gnt", 32'(data_gnt_o), 32'd0);
      chk("full_rsp", 32'({instr_rvalid_o, data_rvalid_o}), 32'd1);
      chk("full_rdata", data_rdata_o, 32'h11);
      tick();

      // Count 1: grant and response in the same cycle.
      mem_rdata_i = 32'h22;
      #1;
      chk("same_req", 32'(mem_req_o), 32'd1);
      chk("same_gnt", 32'(data_gnt_o), 32'd1);
      chk("same_rsp", 32'({instr_rvalid_o, data_rvalid_o}), 32'd2);
      tick();
      data_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rdata_i = 32'h33;
      #1;
      chk("same_rsp2", 32'({instr_rvalid_o, data_rvalid_o, spurious_rvalid_o}), 32'd2);
      tick();
      #1;
      chk("empty_spur", 32'({instr_rvalid_o, data_rvalid_o, spurious_rvalid_o}), 32'd1);
      tick();
      idle();

      // Reset with two transactions outstanding; late response is spurious.
      instr_req_i = 1'b1; instr_addr_i = 32'h500; mem_gnt_i = 1'b1;
      tick();
      instr_req_i = 1'b0; data_req_i = 1'b1; data_addr_i = 32'h600;
      #1;
      chk("pre_rst_gnt", 32'(data_gnt_o), 32'd1);
      tick();
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'h77;
      #1;
      chk("post_rst_spur", 32'({instr_rvalid_o, data_rvalid_o, spurious_rvalid_o}), 32'd1);
      tick();
      mem_rvalid_i = 1'b0;
      instr_req_i = 1'b1; instr_addr_i = 32'h700;
      #1;
      chk("post_rst_quiet", 32'(spurious_rvalid_o), 32'd0);
      chk("post_rst_req", 32'(mem_req_o), 32'd1);
      tick();
      idle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/zeroriscy_mem_arbiter.md
# zeroriscy_mem_arbiter

Shares a single req/gnt/rvalid memory port between the instruction-fetch port (prefetch buffer master) and the load-store-unit data port. Sits between the core and the single-ported memory/interconnect. Arbitrates per request, keeps arbitration stable until grant, and routes in-order responses back to the owning requester. Data is favoured, with an anti-starvation counter that guarantees fetch progress.

## Interface
Parameters:
- MAX_OUTSTANDING, 2: accepted-but-unanswered bus transactions tracked (1..4).
- DATA_STREAK_MAX, 4: consecutive data grants allowed while a fetch waits before fetch is forced first (1..15).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_req_i  in  1  fetch request; held with address until instr_gnt_o.
- instr_addr_i  in  32  fetch word address.
- instr_gnt_o  out  1  fetch request accepted this cycle.
- instr_rvalid_o  out  1  fetch response valid.
- instr_rdata_o  out  32  fetch response data.
- data_req_i  in  1  LSU request; held with all attributes until data_gnt_o.
- data_addr_i  in  32  LSU address.
- data_we_i  in  1  1 = store.
- data_be_i  in  4  byte enables.
- data_wdata_i  in  32  store data.
- data_gnt_o  out  1  LSU request accepted.
- data_rvalid_o  out  1  LSU response valid (loads and stores).
- data_rdata_o  out  32  LSU response data.
- mem_req_o  out  1  bus request.
- mem_addr_o  out  32  bus address.
- mem_we_o  out  1  bus write enable (0 for fetch).
- mem_be_o  out  4  bus byte enables (4'b1111 for fetch).
- mem_wdata_o  out  32  bus write data (0 for fetch).
- mem_gnt_i  in  1  bus accepted request.
- mem_rvalid_i  in  1  bus response valid; responses strictly in order.
- mem_rdata_i  in  32  bus response data.
- spurious_rvalid_o  out  1  one-cycle pulse: mem_rvalid_i with no tracked transaction.

## Operation
- Selection when unlocked: both requesting -> data, unless streak == DATA_STREAK_MAX, then instr. Single requester wins.
- mem_req_o = selected requester's req AND count < MAX_OUTSTANDING. Bus fields mux from selected requester.
- Lock: if mem_req_o asserted and mem_gnt_i low, register lock = selected owner; next cycles select the locked owner regardless of priority until its grant. Lock clears on grant.
- Grant: instr_gnt_o / data_gnt_o = mem_gnt_i AND mem_req_o AND owner selected. On grant push owner id into owner FIFO.
- Streak counter: data grant while instr_req_i high -> increment (saturate at DATA_STREAK_MAX); instr grant or instr_req_i low -> clear.
- Response: mem_rvalid_i with FIFO non-empty -> pop head, assert rvalid of head owner. rdata outputs both driven by mem_rdata_i unconditionally.
- mem_rvalid_i with FIFO empty -> dropped, spurious_rvalid_o pulses.
- Same-cycle grant and response: push and pop both happen; count unchanged.
- Full: count == MAX_OUTSTANDING blocks mem_req_o even if a pop occurs that cycle (no rvalid-to-req path); lock retained.
- A requester deasserting req while locked is a protocol violation; lock clears and selection re-evaluates.

## Timing
- Arbitration and grant fully combinational: zero-cycle added latency, gnt in same cycle as mem_gnt_i.
- Response routing combinational: rvalid out same cycle as mem_rvalid_i.
- Registered state: lock valid/owner, streak (4 bits), owner FIFO + count.
- Reset: all state cleared; every output 0 except rdata outputs (follow mem_rdata_i). Reset mid-transaction discards tracked owners; later late responses flag spurious_rvalid_o.

## Structure
- zeroriscy_defines: add owner enum OWNER_INSTR/OWNER_DATA (1 bit) and constant FETCH_BE = 4'b1111.
- Sub-module zeroriscy_arb_owner_fifo: depth MAX_OUTSTANDING, 1-bit entries, push/pop/full/empty/count, synchronous active-high reset.

## Test plan
- Only instr_req_i, addr 0x80, mem_gnt_i=1, rvalid 1 cycle later data 0x13 -> instr_gnt_o same cycle, instr_rvalid_o with 0x13, data_rvalid_o 0.
- Both requesting continuously, gnt always 1, DATA_STREAK_MAX=4 -> grant order D,D,D,D,I,D,D,D,D,I.
- Data selected, mem_gnt_i low 3 cycles while instr also requests -> mem_addr_o stays data address, data_gnt_o on 4th cycle, no instr grant before.
- MAX_OUTSTANDING=2, two grants, no rvalid -> third request sees mem_req_o=0; rvalid returns -> mem_req_o next cycle; responses routed I then D as issued.
- Grant and rvalid in same cycle at count 1 -> count stays 1, correct owner receives response.
- rst high mid-flight with 2 outstanding, then rvalid -> no requester rvalid, spurious_rvalid_o pulses once.
